cmd_fifo: RTL and testbench
===========================

# cmd_fifo

Command buffer between the Nios II software port and the robot-link serial transmitter. Software presents a byte on a PIO output and toggles a write-strobe PIO bit. This block captures one entry per strobe rising edge into a circular buffer. It drains entries to the transmitter over a valid/ready handshake and drives the `wrfull` flag read back by software through the wrfull PIO input.

## Interface
Parameters:
- `DATA_W`, 8, entry width in bits.
- `DEPTH`, 16, number of entries; must be a power of two, ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

Ports:
- `clk`  in  1  system clock. One clock, shared with the PIO and the transmitter.
- `reset`  in  1  synchronous, active-high reset.
- `wrdata`  in  `DATA_W`  write data, driven by the PIO output register.
- `wrreq`  in  1  level strobe from PIO; a write occurs on each 0→1 transition.
- `wrfull`  out  1  buffer holds `DEPTH` entries. Feeds the wrfull PIO input.
- `rd_data`  out  `DATA_W`  head entry (show-ahead); valid only while `rd_valid`=1.
- `rd_valid`  out  1  buffer not empty.
- `rd_ready`  in  1  transmitter accepts the head entry this cycle.
- `usedw`  out  `ADDR_W+1`  fill level. Present only under the macro (see Configuration).

## Operation
- Registers: `wr_ptr` and `rd_ptr` (`ADDR_W` bits each), `count` (`ADDR_W+1` bits), `wrreq_q`, and a storage array of `DEPTH`×`DATA_W` with no reset.
- Edge detect: `wr_edge = wrreq & ~wrreq_q`; `wrreq_q <= wrreq` every cycle.
- Push: `push = wr_edge & ~wrfull`. This writes `mem[wr_ptr] <= wrdata` and sets `wr_ptr <= wr_ptr+1`, wrapping modulo `DEPTH`.
- Pop: `pop = rd_valid & rd_ready`. This sets `rd_ptr <= rd_ptr+1`, wrapping modulo `DEPTH`.
- Count update: `+1` on push only, `-1` on pop only, unchanged on both or neither.
- Flags: `wrfull = (count == DEPTH)` and `rd_valid = (count != 0)`, both decoded from registered `count`. `rd_data = mem[rd_ptr]`, read combinationally.
- Full: a write edge while `wrfull`=1 is discarded silently. This holds even if a pop occurs in the same cycle, because the full test uses the start-of-cycle state. Software must poll `wrfull` before strobing.
- Empty: `rd_ready` is ignored while `rd_valid`=0. A push into an empty buffer cannot pop in the same cycle.
- Full and pop without write edge: the pop proceeds normally and `wrfull` falls the next cycle.
- A `wrreq` held high produces exactly one write. Another write needs `wrreq` to return low for at least one cycle.
- Reset: pointers and `count` go to 0 and `wrreq_q` goes to 1. A strobe held high across reset therefore produces no write. Storage contents are not cleared.
- Reset mid-operation discards all entries. The transmitter sees `rd_valid` drop in the cycle after reset is sampled.

## Timing
- Reset values: `wrfull`=0, `rd_valid`=0, `usedw`=0. `rd_data` is undefined (don't-care while `rd_valid`=0).
- Write-to-output latency: the `wrreq` rise sampled at edge N gives `rd_valid`=1 and the correct `rd_data` after edge N.
- `wrfull` asserts after the edge that performs the `DEPTH`-th push and deasserts after the edge that performs a pop.
- Throughput: one pop per cycle. Pushes are limited to one per two cycles by the strobe protocol.
- `rd_data` changes only after a pop, or after a push into an empty buffer.

## Configuration
- `CMD_FIFO_USEDW_EN` defined: the `usedw` port exists and equals `count`.
- `CMD_FIFO_USEDW_EN` undefined: the port is omitted and all other behaviour is identical.

## Structure
- Package `cmd_fifo_pkg`: default `DATA_W`/`DEPTH` constants.
- Sub-module `rise_detect`: a one-bit registered edge detector with a parameterised reset value (1 here). It is reusable for other PIO strobes.
- Pointer/count logic and storage stay in `cmd_fifo`.

## Test plan
- Reset with `wrreq` held at 1, then release → no write; `rd_valid`=0, `wrfull`=0, `usedw`=0.
- `wrdata`=0xA5, `wrreq` 0→1 with `rd_ready`=0 → one cycle later `rd_valid`=1 and `rd_data`=0xA5. Holding `wrreq` high 10 cycles leaves `usedw`=1.
- 16 strobes of 0x00..0x0F with `rd_ready`=0 → `wrfull`=1. A 17th strobe of 0xFF is dropped. With `rd_ready`=1, the bench pops 0x00..0x0F in order and `rd_valid` falls after the 16th pop.
- Full buffer, with a write edge of 0x55 and `rd_ready`=1 in the same cycle → pop occurs, 0x55 is dropped, `usedw`=15, `wrfull`=0.
- Interleaved pushes and pops over 40 entries → pointers wrap twice and output order matches a reference queue.
- Reset asserted with 5 entries buffered → the next cycle shows `rd_valid`=0 and `usedw`=0, and the following push reads back correctly.

Source files
------------

// File: rtl/cmd_fifo_pkg.sv
// Shared defaults for the software-to-robot-link command buffer.
package cmd_fifo_pkg;
  localparam int CMD_DATA_W = 8;
  localparam int CMD_DEPTH  = 16;
endpackage

// File: rtl/cmd_fifo_rise_detect.sv
// One-bit registered rising-edge detector for PIO strobes; edge_o is combinational from sig_i.
// Reset loads RST_VAL into the history bit, so RST_VAL=1 suppresses a strobe held high through reset.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic edge_o
);
  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= RST_VAL;
    else       sig_q <= sig_i;
  end

  assign edge_o = sig_i & ~sig_q;
endmodule

// File: rtl/cmd_fifo.sv
// Strobe-written circular command buffer, show-ahead valid/ready drain; one-cycle write-to-output latency.
// Writes on a full buffer are dropped silently; optional usedw port under CMD_FIFO_USEDW_EN.
module cmd_fifo
  import cmd_fifo_pkg::*;
#(
  parameter int DATA_W = CMD_DATA_W,
  parameter int DEPTH  = CMD_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              wrreq,
  output logic              wrfull,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
`ifdef CMD_FIFO_USEDW_EN
  output logic [$clog2(DEPTH):0] usedw,
`endif
  input  logic              rd_ready
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_edge, push, pop;

  rise_detect #(.RST_VAL(1'b1)) u_wr_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (wrreq),
    .edge_o (wr_edge)
  );

  assign wrfull   = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];

  // Full test uses start-of-cycle count, so a same-cycle pop never frees room for a write.
  assign push = wr_edge & ~wrfull;
  assign pop  = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wrdata;
  end

`ifdef CMD_FIFO_USEDW_EN
  assign usedw = count_q;
`endif
endmodule

// File: tb/tb_cmd_fifo.sv
// Directed scoreboard bench for cmd_fifo: a reference queue models pushes, drops and pops.
module tb_cmd_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wrdata = 8'h00;
  logic       wrreq = 1'b1;
  logic       rd_ready = 1'b0;
  logic       wrfull, rd_valid;
  logic [7:0] rd_data;
`ifdef CMD_FIFO_USEDW_EN
  logic [4:0] usedw;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic       prev_wr = 1'b1;

  always #5 clk = ~clk;

  cmd_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .wrdata   (wrdata),
    .wrreq    (wrreq),
    .wrfull   (wrfull),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
`ifdef CMD_FIFO_USEDW_EN
    .usedw    (usedw),
`endif
    .rd_ready (rd_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs for one clock edge, updating the reference model alongside.
  task automatic cycle();
    int  n0;
    logic edge_s;
    n0 = exp_q.size();
    edge_s = wrreq & ~prev_wr;
    if (reset) begin
      exp_q.delete();
      prev_wr = 1'b1;
    end else begin
      if (rd_ready && n0 > 0) begin
        chk("pop_data", rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (edge_s && n0 < 16) exp_q.push_back(wrdata);
      prev_wr = wrreq;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, exp_q.size() != 0);
    chk("wrfull", wrfull, exp_q.size() == 16);
`ifdef CMD_FIFO_USEDW_EN
    chk("usedw", usedw, exp_q.size());
`endif
  endtask

  task automatic strobe(input logic [7:0] d);
    wrdata = d;
    wrreq  = 1'b1;
    cycle();
    wrreq  = 1'b0;
    cycle();
  endtask

  initial begin
    // Reset with the strobe held high: release must not write.
    @(posedge clk); #1;
    reset = 1'b1; wrreq = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_full", wrfull, 1'b0);

    // Single write, one-cycle latency, held strobe writes once.
    wrreq = 1'b0; cycle();
    wrdata = 8'hA5; wrreq = 1'b1; cycle();
    chk("first_valid", rd_valid, 1'b1);
    chk("first_data", rd_data, 8'hA5);
    repeat (10) cycle();
    chk("hold_once", exp_q.size(), 1);
    wrreq = 1'b0; rd_ready = 1'b1; cycle();
    rd_ready = 1'b0; cycle();

    // Fill to full, drop 17th, drain in order.
    for (int i = 0; i < 16; i++) strobe(8'(i));
    chk("full_set", wrfull, 1'b1);
    strobe(8'hFF);
    chk("drop_17th_data", rd_data, 8'h00);
    rd_ready = 1'b1;
    repeat (16) cycle();
    chk("drained_valid", rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Full + write edge + pop in the same cycle: the write is dropped.
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
    wrdata = 8'h55; wrreq = 1'b1; rd_ready = 1'b1;
    cycle();
    chk("fullpop_full", wrfull, 1'b0);
    chk("fullpop_head", rd_data, 8'h21);
    wrreq = 1'b0;
    repeat (15) cycle();
    chk("fullpop_empty", rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Interleaved traffic, 40 entries, pointers wrap twice.
    for (int i = 0; i < 40; i++) begin
      wrdata = 8'($urandom);
      wrreq = 1'b1; rd_ready = 1'($urandom_range(0, 1));
      cycle();
      wrreq = 1'b0; rd_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    rd_ready = 1'b1;
    repeat (20) cycle();
    chk("inter_empty", rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Reset with 5 entries buffered, then a fresh push.
    for (int i = 0; i < 5; i++) strobe(8'(8'h70 + i));
    reset = 1'b1; cycle();
    chk("midrst_valid", rd_valid, 1'b0);
    reset = 1'b0; wrreq = 1'b0; cycle();
    wrdata = 8'h3C; wrreq = 1'b1; cycle();
    chk("post_rst_data", rd_data, 8'h3C);
    wrreq = 1'b0; rd_ready = 1'b1; cycle();
    chk("post_rst_empty", rd_valid, 1'b0);
    rd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
